icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache serving the pre-IF fetch port. It accepts the request fields the pre-IF stage drives: `inst_valid`, `inst_op`, `inst_index`, `inst_tag` and `inst_offset`. It answers with `inst_addr_ok`, `inst_data_ok` and `inst_rdata`. On a miss it refills one 16-byte line from memory through a single-request, 4-beat read-burst port. It sits between the IF stages and the memory/AXI bridge.

## Interface
- `SETS`, 256, number of lines; index width 8.
- `LINE_WORDS`, 4, 32-bit words per line; offset width 4.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `inst_valid` in 1: request present.
- `inst_op` in 1: 0 = read; 1 is treated as read.
- `inst_index` in 8: set select.
- `inst_tag` in 20: physical tag.
- `inst_offset` in 4: byte offset; bits [3:2] select the word.
- `inst_addr_ok` out 1: request accepted this cycle when `inst_valid` is also high.
- `inst_data_ok` out 1: `inst_rdata` valid this cycle.
- `inst_rdata` out 32: fetched instruction word.
- `rd_req` out 1: refill request.
- `rd_type` out 3: fixed 3'b100, whole line.
- `rd_addr` out 32: {tag, index, 4'b0}.
- `rd_rdy` in 1: memory accepts `rd_req`.
- `ret_valid` in 1: return beat valid.
- `ret_last` in 1: final beat.
- `ret_data` in 32: beat data, word 0..3 in ascending address order.

## Operation
- Storage per set: valid bit, 20-bit tag, 128-bit line.
- Request buffer: index, tag, offset. It loads on `inst_valid & inst_addr_ok`.
- States:
  - IDLE: no request in flight.
  - LOOKUP: compare the buffered tag.
  - MISS: `rd_req` held high.
  - REFILL: collecting beats.
- Transitions:
  - IDLE → LOOKUP on accept.
  - LOOKUP hit: `inst_data_ok`=1. Go to LOOKUP if a new request is accepted in the same cycle, else IDLE.
  - LOOKUP miss → MISS.
  - MISS → REFILL on `rd_rdy`.
  - REFILL, on `ret_valid & ret_last`: write the line, set its valid bit, write the tag, go to IDLE.
- `inst_addr_ok` = (state==IDLE) | (state==LOOKUP & hit). It is a function of state and stored contents only and never depends on `inst_valid`; the requester gates `inst_valid` on it.
- Hit = valid[buf_index] & (tag[buf_index]==buf_tag). On a hit, `inst_rdata` = line word buf_offset[3:2].
- Refill:
  - Beat counter 0..3 fills a line buffer.
  - In the `ret_last` beat, `inst_data_ok`=1 and `inst_rdata` = the requested word, taken from the buffer or from `ret_data` if the requested word is beat 3.
  - No new request is accepted in that cycle.
- Refill overwrites the set unconditionally; there is no dirty state and no writeback.
- `ret_valid` is ignored outside REFILL.
- `ret_valid` in REFILL without `ret_last` after 4 beats: the counter saturates at 3 and the last beat wins.

## Timing
- Reset values:
  - state IDLE; all valid bits 0.
  - `inst_addr_ok`=1 (IDLE); `inst_data_ok`=0; `inst_rdata`=0.
  - `rd_req`=0; `rd_addr`=0; beat counter 0.
- Hit latency: accept at cycle T, `inst_data_ok` at T+1. A hit stream sustains one request per cycle.
- Miss:
  - accept T, LOOKUP T+1, `rd_req` from T+2 until the cycle `rd_rdy`=1 (inclusive).
  - `rd_addr` stable while `rd_req` is high.
  - `inst_data_ok` in the `ret_last` cycle.
  - `inst_addr_ok` high again from the next cycle.
- Reset mid-MISS/REFILL: the line is not written, valid bits clear, state is IDLE next cycle. Late beats are discarded.
- Requests with `inst_valid`=0 are never accepted; `inst_addr_ok` may be high without a handshake.
- Same-set requests back-to-back after a refill see the new line; the write completes before the IDLE cycle.

## Structure
- Shared `icache_defines.vh`:
  - `ICACHE_INDEX_WD`=8, `ICACHE_TAG_WD`=20, `ICACHE_OFFSET_WD`=4.
  - state encodings.
  - `RD_TYPE_LINE`=3'b100.
- Sub-module `icache_line_ram`: a 256-entry {valid, tag, data} array with combinational read and synchronous write, plus synchronous clear on `reset`.

## Test plan
- Cold miss:
  - Stimulus: read tag 0x1FC00, index 0x00, offset 0x4; `rd_rdy` at T+2; beats 0x11,0x22,0x33,0x44.
  - Response: `rd_addr`=0x1FC00000; `inst_data_ok` with 0x22 on the last beat.
- Back-to-back hits:
  - Stimulus: after the cold miss, offsets 0x0, 0x8, 0xC in consecutive cycles.
  - Response: `inst_addr_ok` held high; `inst_data_ok` on three consecutive cycles with 0x11, 0x33, 0x44.
- Conflict eviction:
  - Stimulus: tag 0x00001, index 0x00.
  - Response: miss, `rd_addr`=0x00001000. A subsequent 0x1FC00 access misses again.
- `rd_rdy` stall:
  - Stimulus: hold `rd_rdy`=0 for 5 cycles.
  - Response: `rd_req` high and `rd_addr` constant throughout; `inst_addr_ok`=0.
- Reset mid-refill:
  - Stimulus: assert `reset` after beat 2, then reissue the same address.
  - Response: the reissued request misses, which proves no partial line was written.
- Requested word is beat 3:
  - Stimulus: offset 0xC on a miss.
  - Response: `inst_rdata` equals the `ret_data` of the last beat in that same cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared widths, encodings and small line helpers for the direct-mapped
// instruction cache (top icache, storage icache_line_ram, interfaces in
// icache_if.sv).
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int ICACHE_INDEX_WD  = 8;
    localparam int ICACHE_TAG_WD    = 20;
    localparam int ICACHE_OFFSET_WD = 4;
    localparam int SETS             = 256;
    localparam int LINE_WORDS       = 4;
    localparam int WORD_W           = 32;
    localparam int LINE_W           = LINE_WORDS * WORD_W;

    // Refill request type: whole line.
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } state_e;

    typedef logic [ICACHE_INDEX_WD-1:0]  index_t;
    typedef logic [ICACHE_TAG_WD-1:0]    tag_t;
    typedef logic [ICACHE_OFFSET_WD-1:0] offset_t;
    typedef logic [WORD_W-1:0]           word_t;
    typedef logic [LINE_W-1:0]           line_t;

    // Word w of a line; word 0 sits in the least significant bits.
    function automatic word_t line_word(input line_t l, input logic [1:0] w);
        return l[32*w +: 32];
    endfunction

    // Line with word w replaced by d.
    function automatic line_t line_merge(input line_t l, input logic [1:0] w, input word_t d);
        line_t r;
        r = l;
        r[32*w +: 32] = d;
        return r;
    endfunction

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache interfaces
// icache_cpu_if : pre-IF fetch port. master = fetch stage, slave = cache.
//   inst_valid/op/index/tag/offset -> cache ; inst_addr_ok/data_ok/rdata <- cache
// icache_mem_if : refill port. master = cache, slave = memory/AXI bridge.
//   rd_req/rd_type/rd_addr -> bridge ; rd_rdy/ret_valid/ret_last/ret_data <- bridge
// -----------------------------------------------------------------------------
interface icache_cpu_if;
    import icache_pkg::*;

    logic    inst_valid;
    logic    inst_op;
    index_t  inst_index;
    tag_t    inst_tag;
    offset_t inst_offset;
    logic    inst_addr_ok;
    logic    inst_data_ok;
    word_t   inst_rdata;

    modport master (
        output inst_valid, inst_op, inst_index, inst_tag, inst_offset,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_valid, inst_op, inst_index, inst_tag, inst_offset,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

interface icache_mem_if;
    import icache_pkg::*;

    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    word_t       ret_data;

    modport master (
        output rd_req, rd_type, rd_addr,
        input  rd_rdy, ret_valid, ret_last, ret_data
    );

    modport slave (
        input  rd_req, rd_type, rd_addr,
        output rd_rdy, ret_valid, ret_last, ret_data
    );
endinterface

// File: rtl/icache_line_ram.sv
// -----------------------------------------------------------------------------
// icache_line_ram
// SETS-entry {valid, tag, line} store. Combinational read, synchronous write.
// reset synchronously clears every valid bit and blocks a write in that cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   rd_idx_i        read set; rd_valid_o/rd_tag_o/rd_line_o its contents
//   we_i            write strobe; wr_idx_i/wr_tag_i/wr_line_i write payload
// -----------------------------------------------------------------------------
module icache_line_ram
    import icache_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  index_t rd_idx_i,
    output logic   rd_valid_o,
    output tag_t   rd_tag_o,
    output line_t  rd_line_o,
    input  logic   we_i,
    input  index_t wr_idx_i,
    input  tag_t   wr_tag_i,
    input  line_t  wr_line_i
);

    logic [SETS-1:0] valid_q;
    tag_t            tag_q  [SETS];
    line_t           line_q [SETS];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a write coinciding with reset is dropped so
    // an interrupted refill never lands in the array.
    always_ff @(posedge clk) begin
        if (we_i && !reset) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped instruction cache, 256 sets x 16-byte lines. Hits answer one
// cycle after acceptance and can stream one request per cycle; a miss issues a
// single whole-line read and collects four beats before answering.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   cpu         fetch port (icache_cpu_if.slave)
//   mem         refill port (icache_mem_if.master)
// -----------------------------------------------------------------------------
module icache
    import icache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    icache_cpu_if.slave  cpu,
    icache_mem_if.master mem
);

    state_e     state_q, state_d;
    index_t     idx_q;
    tag_t       tag_q;
    offset_t    off_q;
    logic [1:0] cnt_q, cnt_d;
    line_t      fill_q;

    logic  ram_valid;
    tag_t  ram_tag;
    line_t ram_line;

    logic  hit, accept, addr_ok;
    logic  beat, last_beat;
    line_t fill_line;

    // Only the word select of the offset matters, and every op is a read.
    logic unused_ok;
    assign unused_ok = ^{cpu.inst_op, cpu.inst_offset[1:0]};

    icache_line_ram u_ram (
        .clk       (clk),
        .reset     (reset),
        .rd_idx_i  (idx_q),
        .rd_valid_o(ram_valid),
        .rd_tag_o  (ram_tag),
        .rd_line_o (ram_line),
        .we_i      (last_beat),
        .wr_idx_i  (idx_q),
        .wr_tag_i  (tag_q),
        .wr_line_i (fill_line)
    );

    assign hit       = (state_q == ST_LOOKUP) && ram_valid && (ram_tag == tag_q);
    assign addr_ok   = (state_q == ST_IDLE) || hit;
    assign accept    = cpu.inst_valid && addr_ok;
    assign beat      = (state_q == ST_REFILL) && mem.ret_valid && !mem.ret_last;
    assign last_beat = (state_q == ST_REFILL) && mem.ret_valid && mem.ret_last;
    // Buffered beats with the incoming beat dropped into the current slot, so
    // the final beat is usable in the same cycle it arrives.
    assign fill_line = line_merge(fill_q, cnt_q, mem.ret_data);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request buffer and line buffer (data only, no reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= cpu.inst_index;
            tag_q <= cpu.inst_tag;
            off_q <= cpu.inst_offset;
        end
        if (beat) begin
            fill_q <= fill_line;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!hit)        state_d = ST_MISS;
                else if (accept) state_d = ST_LOOKUP;
                else             state_d = ST_IDLE;
            end
            ST_MISS: begin
                cnt_d = 2'd0;
                if (mem.rd_rdy) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                // Surplus non-last beats keep overwriting word 3.
                if (beat && cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
                if (last_beat)             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cpu.inst_addr_ok = addr_ok;
        cpu.inst_data_ok = 1'b0;
        cpu.inst_rdata   = '0;
        mem.rd_req       = 1'b0;
        mem.rd_type      = RD_TYPE_LINE;
        mem.rd_addr      = '0;
        if (hit) begin
            cpu.inst_data_ok = 1'b1;
            cpu.inst_rdata   = line_word(ram_line, off_q[3:2]);
        end else if (last_beat) begin
            cpu.inst_data_ok = 1'b1;
            cpu.inst_rdata   = line_word(fill_line, off_q[3:2]);
        end
        if (state_q == ST_MISS) begin
            mem.rd_req  = 1'b1;
            mem.rd_addr = {tag_q, idx_q, 4'b0000};
        end
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    import icache_pkg::*;

    typedef struct {
        logic [19:0]  tag;
        logic [7:0]   idx;
        logic [3:0]   off;
        bit           miss;
        int           stall;
        logic [127:0] beats;     // beat 0 in bits [31:0]
        logic [31:0]  exp_addr;
        logic [31:0]  exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs [8];
    vec_t v;

    icache_cpu_if cpu_if ();
    icache_mem_if mem_if ();

    icache dut (
        .clk  (clk),
        .reset(reset),
        .cpu  (cpu_if),
        .mem  (mem_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete request; a miss is served by a bench-side memory responder.
    task automatic fetch(input vec_t t, input string nm);
        int w;
        tick();
        cpu_if.inst_valid  = 1'b1;
        cpu_if.inst_tag    = t.tag;
        cpu_if.inst_index  = t.idx;
        cpu_if.inst_offset = t.off;
        @(negedge clk);
        w = 0;
        while (!cpu_if.inst_addr_ok && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({nm, " addr_ok"}, {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        tick();
        cpu_if.inst_valid = 1'b0;
        @(negedge clk);
        if (!t.miss) begin
            check({nm, " hit data_ok"}, {31'd0, cpu_if.inst_data_ok}, 32'd1);
            check({nm, " hit rdata"}, cpu_if.inst_rdata, t.exp_data);
            return;
        end
        check({nm, " lookup data_ok"}, {31'd0, cpu_if.inst_data_ok}, 32'd0);
        tick();
        mem_if.rd_rdy = (t.stall == 0);
        @(negedge clk);
        check({nm, " rd_req"}, {31'd0, mem_if.rd_req}, 32'd1);
        check({nm, " rd_addr"}, mem_if.rd_addr, t.exp_addr);
        check({nm, " miss addr_ok"}, {31'd0, cpu_if.inst_addr_ok}, 32'd0);
        for (int k = 1; k <= t.stall; k++) begin
            tick();
            mem_if.rd_rdy = (k == t.stall);
            @(negedge clk);
            check({nm, " stall rd_req"}, {31'd0, mem_if.rd_req}, 32'd1);
            check({nm, " stall rd_addr"}, mem_if.rd_addr, t.exp_addr);
            check({nm, " stall addr_ok"}, {31'd0, cpu_if.inst_addr_ok}, 32'd0);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            mem_if.rd_rdy    = 1'b0;
            mem_if.ret_valid = 1'b1;
            mem_if.ret_last  = (b == 3);
            mem_if.ret_data  = t.beats[32*b +: 32];
            @(negedge clk);
            if (b == 0)
                check({nm, " refill rd_req"}, {31'd0, mem_if.rd_req}, 32'd0);
            check({nm, " beat data_ok"}, {31'd0, cpu_if.inst_data_ok}, (b == 3) ? 32'd1 : 32'd0);
        end
        check({nm, " refill rdata"}, cpu_if.inst_rdata, t.exp_data);
        check({nm, " last addr_ok"}, {31'd0, cpu_if.inst_addr_ok}, 32'd0);
        tick();
        mem_if.ret_valid = 1'b0;
        mem_if.ret_last  = 1'b0;
        @(negedge clk);
        check({nm, " after addr_ok"}, {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        check({nm, " after data_ok"}, {31'd0, cpu_if.inst_data_ok}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{20'h1FC00, 8'h00, 4'h4, 1'b1, 0, {32'h44, 32'h33, 32'h22, 32'h11}, 32'h1FC00000, 32'h22};
        vecs[1] = '{20'h00001, 8'h00, 4'h0, 1'b1, 0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'h00001000, 32'hA0};
        vecs[2] = '{20'h1FC00, 8'h00, 4'h4, 1'b1, 0, {32'h88, 32'h77, 32'h66, 32'h55}, 32'h1FC00000, 32'h66};
        vecs[3] = '{20'h12345, 8'h5A, 4'hC, 1'b1, 0, {32'h4, 32'h3, 32'h2, 32'h1}, 32'h123455A0, 32'h4};
        vecs[4] = '{20'h12345, 8'h5A, 4'hC, 1'b0, 0, 128'h0, 32'h0, 32'h4};
        vecs[5] = '{20'hABCDE, 8'hFF, 4'h8, 1'b1, 5, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 32'hABCDEFF0, 32'hD2};
        vecs[6] = '{20'h1FC00, 8'h00, 4'h0, 1'b0, 0, 128'h0, 32'h0, 32'h55};
        vecs[7] = '{20'h00001, 8'h00, 4'h0, 1'b1, 0, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 32'h00001000, 32'hB0};

        cpu_if.inst_valid  = 1'b0;
        cpu_if.inst_op     = 1'b0;
        cpu_if.inst_tag    = '0;
        cpu_if.inst_index  = '0;
        cpu_if.inst_offset = '0;
        mem_if.rd_rdy      = 1'b0;
        mem_if.ret_valid   = 1'b0;
        mem_if.ret_last    = 1'b0;
        mem_if.ret_data    = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset addr_ok", {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        check("reset data_ok", {31'd0, cpu_if.inst_data_ok}, 32'd0);
        check("reset rdata", cpu_if.inst_rdata, 32'd0);
        check("reset rd_req", {31'd0, mem_if.rd_req}, 32'd0);
        check("reset rd_addr", mem_if.rd_addr, 32'd0);
        check("rd_type", {29'd0, mem_if.rd_type}, 32'd4);

        // Cold miss, then three back-to-back hits on the same line.
        fetch(vecs[0], "cold");
        tick();
        cpu_if.inst_valid  = 1'b1;
        cpu_if.inst_tag    = 20'h1FC00;
        cpu_if.inst_index  = 8'h00;
        cpu_if.inst_offset = 4'h0;
        @(negedge clk);
        check("b2b addr_ok0", {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        tick();
        cpu_if.inst_offset = 4'h8;
        @(negedge clk);
        check("b2b addr_ok1", {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        check("b2b data_ok1", {31'd0, cpu_if.inst_data_ok}, 32'd1);
        check("b2b rdata1", cpu_if.inst_rdata, 32'h11);
        tick();
        cpu_if.inst_offset = 4'hC;
        @(negedge clk);
        check("b2b addr_ok2", {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        check("b2b data_ok2", {31'd0, cpu_if.inst_data_ok}, 32'd1);
        check("b2b rdata2", cpu_if.inst_rdata, 32'h33);
        tick();
        cpu_if.inst_valid = 1'b0;
        @(negedge clk);
        check("b2b data_ok3", {31'd0, cpu_if.inst_data_ok}, 32'd1);
        check("b2b rdata3", cpu_if.inst_rdata, 32'h44);
        tick();
        @(negedge clk);
        check("b2b idle data_ok", {31'd0, cpu_if.inst_data_ok}, 32'd0);
        check("b2b idle addr_ok", {31'd0, cpu_if.inst_addr_ok}, 32'd1);

        // Eviction, re-miss, beat-3 word, hit, stall, untouched set, re-miss.
        for (int i = 1; i < 8; i++) begin
            fetch(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset after the second refill beat.
        tick();
        cpu_if.inst_valid  = 1'b1;
        cpu_if.inst_tag    = 20'h0F0F0;
        cpu_if.inst_index  = 8'h33;
        cpu_if.inst_offset = 4'h0;
        tick();
        cpu_if.inst_valid = 1'b0;
        tick();
        mem_if.rd_rdy = 1'b1;
        tick();
        mem_if.rd_rdy    = 1'b0;
        mem_if.ret_valid = 1'b1;
        mem_if.ret_data  = 32'hC0;
        tick();
        mem_if.ret_data = 32'hC1;
        tick();
        mem_if.ret_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst mid addr_ok", {31'd0, cpu_if.inst_addr_ok}, 32'd1);
        check("rst mid rd_req", {31'd0, mem_if.rd_req}, 32'd0);
        tick();
        mem_if.ret_valid = 1'b1;
        mem_if.ret_last  = 1'b1;
        mem_if.ret_data  = 32'hDEAD;
        @(negedge clk);
        check("late beat data_ok", {31'd0, cpu_if.inst_data_ok}, 32'd0);
        tick();
        mem_if.ret_valid = 1'b0;
        mem_if.ret_last  = 1'b0;
        v = '{20'h0F0F0, 8'h33, 4'h0, 1'b1, 0, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 32'h0F0F0330, 32'hE0};
        fetch(v, "reissue");
        // Reset also dropped the line at set 0.
        v = '{20'h00001, 8'h00, 4'h4, 1'b1, 0, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 32'h00001000, 32'hF1};
        fetch(v, "post-reset set0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
